cam_init_seq: RTL and testbench
===============================

// Module: cam_init_seq
// PURPOSE
//  Camera register-init sequencer; drives the 24-bit I2C write engine (sendit/done/ack handshake, 25 MHz).
//  After power-up wait, walks a synchronous ROM of {reg_addr[15:0], reg_data[7:0]} entries and issues one I2C write per entry.
//  Handles NACK retries, delay entries and transaction timeout; reports done/error to the top-level VGA/camera design.
// PARAMETERS
//  NUM_REGS        64         number of ROM entries executed (1..2**ROM_AW)
//  ROM_AW          6          ROM address width
//  POWERUP_CYCLES  2_500_000  clocks waited after start before the first entry (100 ms @25 MHz)
//  MS_CYCLES       25_000     clocks per millisecond for delay entries
//  RETRY_MAX       3          retries per entry after NACK/timeout (attempts = RETRY_MAX+1)
//  TIMEOUT_CYCLES  250_000    max clocks waiting for i2c_done per attempt (10 ms)
//  GAP_CYCLES      2_500      idle clocks between transactions (100 us)
// PORTS
//  meg25         in   1       25 MHz clock
//  reset_n       in   1       asynchronous active-low reset
//  start         in   1       level/pulse; rising edge sampled in IDLE, DONE or ERR starts a sequence
//  rom_addr      out  ROM_AW  entry index to ROM
//  rom_data      in   24      ROM word, valid 1 clock after rom_addr changes
//  i2c_send_dat  out  24      payload to I2C engine, stable while i2c_sendit=1
//  i2c_sendit    out  1       transaction request to I2C engine
//  i2c_done      in   1       engine completion flag (level)
//  i2c_ack       in   1       engine sticky NACK flag (1 = a byte not acknowledged)
//  i2c_reset     out  1       active-high clear of engine NACK flag, 1-clock pulse
//  busy          out  1       1 from accepted start until DONE/ERR
//  cfg_done      out  1       1 in DONE, held until next start or reset
//  cfg_err       out  1       1 in ERR, held until next start or reset
//  err_index     out  ROM_AW  index of failing entry, valid while cfg_err=1
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; all outputs 0; counters, index, retry count 0.
//  States: IDLE -> PWRUP (POWERUP_CYCLES) -> FETCH (drive rom_addr=idx) -> LATCH (capture rom_data, 1 clk later)
//   -> if rom_data[23:8]==16'hFFFF: DELAY (rom_data[7:0]*MS_CYCLES clocks; 0 = no wait) -> NEXT
//   -> else CLR (i2c_reset=1 one clock, retry not touched) -> SEND -> RELEASE -> CHECK.
//  SEND: i2c_sendit=1, i2c_send_dat=latched word; wait i2c_done=1; timeout counter runs from SEND entry.
//  RELEASE: i2c_sendit=0; wait i2c_done=0 (no timeout count; engine clears on next bit tick).
//  CHECK: i2c_ack sampled: 0 -> GAP then NEXT; 1 (NACK) or timeout -> retry.
//  Timeout in SEND: drop i2c_sendit, go RELEASE with timeout flag set, evaluated in CHECK as failure.
//  Retry: retry<RETRY_MAX -> retry+1, GAP, back to CLR; else ERR, err_index=idx.
//  NEXT: retry=0; idx==NUM_REGS-1 -> DONE else idx+1 -> FETCH. No wrap beyond NUM_REGS-1.
//  start edge detection: registered start; edge while busy is ignored. Restart from DONE/ERR clears cfg_done,
//   cfg_err, idx and retry, and skips PWRUP only if the previous run reached DONE.
//  Counters sized for max(POWERUP_CYCLES, 255*MS_CYCLES, TIMEOUT_CYCLES); delay product computed at full width.
//  i2c_send_dat changes only in LATCH; never while i2c_sendit=1.
//  reset_n asserted mid-transaction: i2c_sendit drops asynchronously to 0; engine returns to idle on its own.
// STRUCTURE
//  Shared package: state encoding localparams, DELAY_MARKER=16'hFFFF, entry field offsets (ADDR_MSB/LSB, DATA_MSB/LSB).
//  One sub-module natural: cam_init_rom (sync ROM, $readmemh of entry table, ROM_AW address, 24-bit data).
//  Sequencer FSM, shared down-counter (pwrup/delay/gap) and separate timeout counter stay in this module.
// TESTING
//  Bench uses a behavioural I2C engine model (done after N clocks, programmable NACK); POWERUP/MS/TIMEOUT scaled down.
//  Reset then start, 3 entries, all ACK -> 3 sendit windows with payloads = ROM words in order, cfg_done=1, busy=0.
//  Entry 1 = 24'hFFFF05, MS_CYCLES=10 -> 50 clocks between RELEASE of entry 0 and next sendit, no I2C traffic for it.
//  Entry 2 NACKs twice then ACKs, RETRY_MAX=3 -> 3 attempts, i2c_reset pulse before each, cfg_done=1.
//  Entry 2 always NACK -> 4 attempts, cfg_err=1, err_index=2, no further sendit.
//  Model never raises done, TIMEOUT_CYCLES=100 -> sendit dropped after 100 clocks, retried, then cfg_err=1.
//  reset_n low during SEND -> sendit=0 immediately, all outputs 0; start edge while busy -> ignored.

Source files
------------

// File: rtl/cam_init_seq_pkg.sv
// Shared types and constants for the camera register-init sequencer.
package cam_init_seq_pkg;

  localparam int unsigned ENTRY_W  = 24;
  localparam int unsigned ADDR_MSB = 23;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  // An entry whose register-address field equals this marker is a millisecond delay, not a write.
  localparam logic [15:0] DELAY_MARKER = 16'hFFFF;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic [3:0] {
    StIdle,
    StPwrup,
    StFetch,
    StLatch,
    StDelay,
    StClr,
    StSend,
    StRelease,
    StCheck,
    StGap,
    StNext,
    StDone,
    StErr
  } seq_state_e;

  function automatic logic is_delay(entry_t e);
    return e[ADDR_MSB:ADDR_LSB] == DELAY_MARKER;
  endfunction

endpackage

// File: rtl/cam_init_seq_if.sv
// Handshake between the init sequencer (master) and the 24-bit I2C write engine (slave).
interface cam_init_seq_if;
  import cam_init_seq_pkg::*;

  entry_t i2c_send_dat;
  logic   i2c_sendit;
  logic   i2c_done;
  logic   i2c_ack;
  logic   i2c_reset;

  modport master (
    output i2c_send_dat,
    output i2c_sendit,
    output i2c_reset,
    input  i2c_done,
    input  i2c_ack
  );

  modport slave (
    input  i2c_send_dat,
    input  i2c_sendit,
    input  i2c_reset,
    output i2c_done,
    output i2c_ack
  );

endinterface

// File: rtl/cam_init_seq.sv
// Camera register-init sequencer: waits out power-up, then walks the entry ROM issuing one I2C
// write per entry, honouring delay entries, NACK retries and a per-attempt timeout.
module cam_init_seq
  import cam_init_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 64,
  parameter int unsigned ROM_AW         = 6,
  parameter int unsigned POWERUP_CYCLES = 2_500_000,
  parameter int unsigned MS_CYCLES      = 25_000,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 250_000,
  parameter int unsigned GAP_CYCLES     = 2_500
) (
  input  logic              meg25,
  input  logic              reset_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  entry_t            rom_data,
  cam_init_seq_if.master    i2c,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [ROM_AW-1:0] err_index
);

  localparam int unsigned DelayMax = 255 * MS_CYCLES;
  localparam int unsigned Max1     = (POWERUP_CYCLES > DelayMax) ? POWERUP_CYCLES : DelayMax;
  localparam int unsigned Max2     = (Max1 > TIMEOUT_CYCLES) ? Max1 : TIMEOUT_CYCLES;
  localparam int unsigned CntMax   = (Max2 > GAP_CYCLES) ? Max2 : GAP_CYCLES;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam int unsigned RetryW   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [CntW-1:0]   PwrupCnt = CntW'(POWERUP_CYCLES);
  localparam logic [CntW-1:0]   GapCnt   = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0]   MsCnt    = CntW'(MS_CYCLES);
  localparam logic [CntW-1:0]   TmoLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(RETRY_MAX);
  localparam logic [ROM_AW-1:0] LastIdx  = ROM_AW'(NUM_REGS - 1);

  seq_state_e        state_q, state_d;
  logic              start_q, start_edge;
  logic [CntW-1:0]   cnt_q, cnt_d, tmo_q, tmo_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic              gap_retry_q, gap_retry_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [ROM_AW-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
  entry_t            word_q, word_d;

  assign start_edge = start & ~start_q;

  always_ff @(posedge meg25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      tmo_flag_q  <= 1'b0;
      gap_retry_q <= 1'b0;
      retry_q     <= '0;
      idx_q       <= '0;
      err_idx_q   <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      tmo_flag_q  <= tmo_flag_d;
      gap_retry_q <= gap_retry_d;
      retry_q     <= retry_d;
      idx_q       <= idx_d;
      err_idx_q   <= err_idx_d;
      word_q      <= word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    tmo_flag_d  = tmo_flag_q;
    gap_retry_d = gap_retry_q;
    retry_d     = retry_q;
    idx_d       = idx_q;
    err_idx_d   = err_idx_q;
    word_d      = word_q;
    unique case (state_q)
      StIdle, StErr: begin
        if (start_edge) begin
          idx_d     = '0;
          retry_d   = '0;
          err_idx_d = '0;
          cnt_d     = PwrupCnt;
          state_d   = (POWERUP_CYCLES != 0) ? StPwrup : StFetch;
        end
      end
      // A completed run leaves the camera powered, so a restart goes straight to the table.
      StDone: begin
        if (start_edge) begin
          idx_d   = '0;
          retry_d = '0;
          state_d = StFetch;
        end
      end
      StPwrup: begin
        if (cnt_q <= CntW'(1)) state_d = StFetch;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        word_d = rom_data;
        if (is_delay(rom_data)) begin
          cnt_d   = CntW'(rom_data[DATA_MSB:DATA_LSB]) * MsCnt;
          state_d = (rom_data[DATA_MSB:DATA_LSB] == 8'd0) ? StNext : StDelay;
        end else begin
          state_d = StClr;
        end
      end
      StDelay: begin
        if (cnt_q <= CntW'(1)) state_d = StNext;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StClr: begin
        tmo_d      = '0;
        tmo_flag_d = 1'b0;
        state_d    = StSend;
      end
      StSend: begin
        if (i2c.i2c_done) begin
          state_d = StRelease;
        end else if (tmo_q == TmoLast) begin
          tmo_flag_d = 1'b1;
          state_d    = StRelease;
        end else begin
          tmo_d = tmo_q + CntW'(1);
        end
      end
      StRelease: if (!i2c.i2c_done) state_d = StCheck;
      StCheck: begin
        cnt_d = GapCnt;
        if (!i2c.i2c_ack && !tmo_flag_q) begin
          gap_retry_d = 1'b0;
          state_d     = (GAP_CYCLES != 0) ? StGap : StNext;
        end else if (retry_q < RetryMax) begin
          retry_d     = retry_q + RetryW'(1);
          gap_retry_d = 1'b1;
          state_d     = (GAP_CYCLES != 0) ? StGap : StClr;
        end else begin
          err_idx_d = idx_q;
          state_d   = StErr;
        end
      end
      StGap: begin
        if (cnt_q <= CntW'(1)) state_d = gap_retry_q ? StClr : StNext;
        else                   cnt_d   = cnt_q - CntW'(1);
      end
      StNext: begin
        retry_d = '0;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + ROM_AW'(1);
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded from the async-reset state register, so sendit falls immediately on reset.
  assign i2c.i2c_send_dat = word_q;
  assign i2c.i2c_sendit   = (state_q == StSend);
  assign i2c.i2c_reset    = (state_q == StClr);

  assign rom_addr  = idx_q;
  assign err_index = err_idx_q;
  assign busy      = !(state_q inside {StIdle, StDone, StErr});
  assign cfg_done  = (state_q == StDone);
  assign cfg_err   = (state_q == StErr);

endmodule

// File: tb/tb_cam_init_seq.sv
// Self-checking bench for cam_init_seq: behavioural ROM and I2C engine, queue-based reference model.
module tb_cam_init_seq;
  import cam_init_seq_pkg::*;

  localparam int unsigned NUM_REGS = 3;
  localparam int unsigned ROM_AW   = 4;
  localparam int unsigned POWERUP  = 20;
  localparam int unsigned MS       = 10;
  localparam int unsigned RETRY    = 3;
  localparam int unsigned TIMEOUT  = 100;
  localparam int unsigned GAP      = 5;
  localparam int unsigned Bound    = 5000;

  logic              meg25 = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ROM_AW-1:0] rom_addr, err_index;
  entry_t            rom_data;
  logic              busy, cfg_done, cfg_err;

  cam_init_seq_if ifc ();

  cam_init_seq #(
    .NUM_REGS      (NUM_REGS),
    .ROM_AW        (ROM_AW),
    .POWERUP_CYCLES(POWERUP),
    .MS_CYCLES     (MS),
    .RETRY_MAX     (RETRY),
    .TIMEOUT_CYCLES(TIMEOUT),
    .GAP_CYCLES    (GAP)
  ) dut (
    .meg25    (meg25),
    .reset_n  (reset_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .i2c      (ifc),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .err_index(err_index)
  );

  always #5 meg25 = ~meg25;

  int n_checks = 0;
  int n_fail   = 0;

  // Synchronous ROM
  entry_t rom_mem [16];
  always @(posedge meg25) rom_data <= rom_mem[rom_addr];

  // I2C engine: done after eng_lat clocks, sticky NACK for the first nack_plan[e] attempts
  int nack_plan [NUM_REGS];
  int nack_used [NUM_REGS];
  bit hang = 1'b0;
  bit eng_clear = 1'b0;
  int eng_lat = 4;
  int eng_cnt;

  function automatic int entry_of(entry_t w);
    for (int i = 0; i < NUM_REGS; i++) if (rom_mem[i] == w) return i;
    return 0;
  endfunction

  always @(posedge meg25) begin
    if (eng_clear) for (int i = 0; i < NUM_REGS; i++) nack_used[i] <= 0;
    if (ifc.i2c_reset || eng_clear) ifc.i2c_ack <= 1'b0;
    if (!ifc.i2c_sendit) begin
      ifc.i2c_done <= 1'b0;
      eng_cnt      <= 0;
    end else if (!ifc.i2c_done && !hang) begin
      if (eng_cnt >= eng_lat - 1) begin
        ifc.i2c_done <= 1'b1;
        if (nack_used[entry_of(ifc.i2c_send_dat)] < nack_plan[entry_of(ifc.i2c_send_dat)]) begin
          ifc.i2c_ack <= 1'b1;
          nack_used[entry_of(ifc.i2c_send_dat)] <= nack_used[entry_of(ifc.i2c_send_dat)] + 1;
        end
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  // Bus monitor: sendit windows, reset pulses, payload stability
  int     cyc = 0, rst_cnt = 0, order_err = 0, stab_err = 0;
  bit     rst_seen = 1'b0, sendit_prev = 1'b0;
  entry_t dat_prev;
  entry_t send_q [$];
  int     rise_q [$];
  int     fall_q [$];

  always @(negedge meg25) begin
    cyc         <= cyc + 1;
    sendit_prev <= ifc.i2c_sendit;
    dat_prev    <= ifc.i2c_send_dat;
    if (ifc.i2c_reset) begin
      rst_cnt  <= rst_cnt + 1;
      rst_seen <= 1'b1;
    end
    if (ifc.i2c_sendit && !sendit_prev) begin
      send_q.push_back(ifc.i2c_send_dat);
      rise_q.push_back(cyc);
      if (!rst_seen) order_err <= order_err + 1;
      rst_seen <= 1'b0;
    end
    if (!ifc.i2c_sendit && sendit_prev) fall_q.push_back(cyc);
    if (ifc.i2c_sendit && sendit_prev && ifc.i2c_send_dat !== dat_prev) stab_err <= stab_err + 1;
  end

  // Reference model: expected payload stream and final status from table, NACK plan and hang mode
  entry_t exp_q [$];
  bit     exp_done, exp_err;
  int     exp_idx;

  function automatic void build_model();
    exp_q.delete();
    exp_done = 1'b1;
    exp_err  = 1'b0;
    exp_idx  = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      int tries;
      if (rom_mem[i][23:8] == 16'hFFFF) continue;
      tries = (hang || nack_plan[i] > int'(RETRY)) ? int'(RETRY) + 1 : nack_plan[i] + 1;
      repeat (tries) exp_q.push_back(rom_mem[i]);
      if (hang || nack_plan[i] > int'(RETRY)) begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
        exp_idx  = i;
        break;
      end
    end
  endfunction

  function automatic void fill_rom(bit allow_delay);
    for (int i = 0; i < NUM_REGS; i++) begin
      rom_mem[i]   = {8'($urandom), 8'(i), 8'($urandom)};
      nack_plan[i] = 0;
      if (allow_delay && $urandom_range(0, 3) == 0)
        rom_mem[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
    end
  endfunction

  task automatic kick();
    eng_clear = 1'b1;
    @(negedge meg25);
    eng_clear = 1'b0;
    start = 1'b1;
    @(negedge meg25);
    start = 1'b0;
    repeat (3) @(negedge meg25);
  endtask

  task automatic wait_end(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < Bound; i++) begin
      if (cfg_done || cfg_err) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge meg25);
    end
    repeat (30) @(negedge meg25);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge meg25);
    n_checks++;
    if ({busy, cfg_done, cfg_err, ifc.i2c_sendit, ifc.i2c_reset} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, cfg_done, cfg_err, ifc.i2c_sendit, ifc.i2c_reset});
    end
    n_checks++;
    if (ifc.i2c_send_dat !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_send_dat: got %h expected 000000", ifc.i2c_send_dat);
    end
    n_checks++;
    if (rom_addr !== '0 || err_index !== '0) begin
      n_fail++;
      $display("FAIL reset_index: got rom_addr %0d err_index %0d expected 0 0", rom_addr, err_index);
    end
    reset_n = 1'b1;
    repeat (POWERUP + 10) @(negedge meg25);
    n_checks++;
    if (busy !== 1'b0 || send_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_no_start: got busy %b sends %0d expected 0 0", busy, send_q.size());
    end
  endtask

  task automatic test_basic();
    int base, rbase;
    bit to;
    hang = 1'b0;
    fill_rom(1'b0);
    build_model();
    base  = send_q.size();
    rbase = rst_cnt;
    kick();
    wait_end(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: got no completion expected done"); end
    n_checks++;
    if (send_q.size() - base != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected %0d", send_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && base + k < send_q.size(); k++) begin
      n_checks++;
      if (send_q[base + k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL basic_payload%0d: got %h expected %h", k, send_q[base + k], exp_q[k]);
      end
    end
    n_checks++;
    if ({cfg_done, cfg_err, busy} !== 3'b100 || rst_cnt - rbase != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_status: got done/err/busy %b resets %0d expected 100 %0d",
               {cfg_done, cfg_err, busy}, rst_cnt - rbase, exp_q.size());
    end
  endtask

  task automatic test_delay();
    int d [2];
    bit to;
    hang = 1'b0;
    fill_rom(1'b0);
    for (int r = 0; r < 2; r++) begin
      int bs, bf;
      rom_mem[1] = (r == 0) ? 24'hFFFF00 : 24'hFFFF05;
      bs = send_q.size();
      bf = fall_q.size();
      d[r] = 0;
      kick();
      wait_end(to);
      n_checks++;
      if (to || cfg_done !== 1'b1 || send_q.size() - bs != 2) begin
        n_fail++;
        $display("FAIL delay_run%0d: got done %b sends %0d expected 1 2", r, cfg_done,
                 send_q.size() - bs);
      end else begin
        d[r] = rise_q[bs + 1] - fall_q[bf];
      end
    end
    n_checks++;
    if (d[1] - d[0] != 5 * int'(MS)) begin
      n_fail++;
      $display("FAIL delay_length: got %0d expected %0d", d[1] - d[0], 5 * MS);
    end
  endtask

  task automatic test_nack();
    int plans [2] = '{2, 9};
    for (int c = 0; c < 2; c++) begin
      int base, rbase, obase;
      bit to;
      hang = 1'b0;
      fill_rom(1'b0);
      nack_plan[2] = plans[c];
      build_model();
      base  = send_q.size();
      rbase = rst_cnt;
      obase = order_err;
      kick();
      wait_end(to);
      n_checks++;
      if (to || send_q.size() - base != exp_q.size()) begin
        n_fail++;
        $display("FAIL nack%0d_count: got %0d expected %0d", c, send_q.size() - base,
                 exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && base + k < send_q.size(); k++) begin
        n_checks++;
        if (send_q[base + k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL nack%0d_payload%0d: got %h expected %h", c, k, send_q[base + k], exp_q[k]);
        end
      end
      n_checks++;
      if (rst_cnt - rbase != exp_q.size() || order_err != obase) begin
        n_fail++;
        $display("FAIL nack%0d_resets: got %0d pulses %0d unpreceded expected %0d 0", c,
                 rst_cnt - rbase, order_err - obase, exp_q.size());
      end
      n_checks++;
      if (cfg_done !== exp_done || cfg_err !== exp_err || (exp_err && err_index !== 4'(exp_idx)))
      begin
        n_fail++;
        $display("FAIL nack%0d_status: got done %b err %b idx %0d expected %b %b %0d", c,
                 cfg_done, cfg_err, err_index, exp_done, exp_err, exp_idx);
      end
    end
  endtask

  task automatic test_timeout();
    int bs, bf;
    bit to;
    hang = 1'b1;
    fill_rom(1'b0);
    build_model();
    bs = send_q.size();
    bf = fall_q.size();
    kick();
    wait_end(to);
    n_checks++;
    if (to || send_q.size() - bs != exp_q.size()) begin
      n_fail++;
      $display("FAIL tmo_count: got %0d expected %0d", send_q.size() - bs, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && bs + k < send_q.size() && bf + k < fall_q.size(); k++)
    begin
      n_checks++;
      if (fall_q[bf + k] - rise_q[bs + k] != int'(TIMEOUT) || send_q[bs + k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL tmo_window%0d: got width %0d data %h expected %0d %h", k,
                 fall_q[bf + k] - rise_q[bs + k], send_q[bs + k], TIMEOUT, exp_q[k]);
      end
    end
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0 || err_index !== 4'(exp_idx)) begin
      n_fail++;
      $display("FAIL tmo_status: got err %b done %b idx %0d expected 1 0 %0d", cfg_err, cfg_done,
               err_index, exp_idx);
    end
    hang = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    bit to;
    hang = 1'b0;
    fill_rom(1'b0);
    nack_plan[1] = 1;
    build_model();
    base = send_q.size();
    kick();
    for (int i = 0; i < Bound && send_q.size() <= base; i++) @(negedge meg25);
    start = 1'b1;
    @(negedge meg25);
    start = 1'b0;
    wait_end(to);
    n_checks++;
    if (to || send_q.size() - base != exp_q.size() || cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_count: got %0d done %b expected %0d 1", send_q.size() - base,
               cfg_done, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && base + k < send_q.size(); k++) begin
      n_checks++;
      if (send_q[base + k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL busy_start_payload%0d: got %h expected %h", k, send_q[base + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int base;
      bit to;
      hang = 1'b0;
      eng_lat = $urandom_range(1, 6);
      fill_rom(1'b1);
      for (int i = 0; i < NUM_REGS; i++) nack_plan[i] = $urandom_range(0, 4);
      build_model();
      base = send_q.size();
      kick();
      wait_end(to);
      n_checks++;
      if (to || send_q.size() - base != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d expected %0d", it, send_q.size() - base,
                 exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && base + k < send_q.size(); k++) begin
        n_checks++;
        if (send_q[base + k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rand%0d_payload%0d: got %h expected %h", it, k, send_q[base + k],
                   exp_q[k]);
        end
      end
      n_checks++;
      if (cfg_done !== exp_done || cfg_err !== exp_err || (exp_err && err_index !== 4'(exp_idx)))
      begin
        n_fail++;
        $display("FAIL rand%0d_status: got done %b err %b idx %0d expected %b %b %0d", it,
                 cfg_done, cfg_err, err_index, exp_done, exp_err, exp_idx);
      end
    end
    eng_lat = 4;
  endtask

  task automatic test_reset_mid();
    int base;
    bit to, seen;
    hang = 1'b1;
    fill_rom(1'b0);
    kick();
    seen = 1'b0;
    for (int i = 0; i < Bound; i++) begin
      if (ifc.i2c_sendit) begin
        seen = 1'b1;
        break;
      end
      @(negedge meg25);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rstmid_send: got no sendit expected sendit"); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ifc.i2c_sendit, ifc.i2c_reset, busy, cfg_done, cfg_err} !== 5'b0 ||
        ifc.i2c_send_dat !== 24'h0 || rom_addr !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b dat %h addr %0d expected 00000 000000 0",
               {ifc.i2c_sendit, ifc.i2c_reset, busy, cfg_done, cfg_err}, ifc.i2c_send_dat,
               rom_addr);
    end
    @(negedge meg25);
    reset_n = 1'b1;
    hang = 1'b0;
    repeat (3) @(negedge meg25);
    build_model();
    base = send_q.size();
    kick();
    wait_end(to);
    n_checks++;
    if (to || cfg_done !== 1'b1 || send_q.size() - base != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid_rerun: got done %b sends %0d expected 1 %0d", cfg_done,
               send_q.size() - base, exp_q.size());
    end
    n_checks++;
    if (stab_err != 0) begin
      n_fail++;
      $display("FAIL send_dat_stable: got %0d changes expected 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
